seg_scan_ctrl: RTL and testbench

//  Time-multiplexed scan controller for a bank of NDIG seven-segment digits that share one BCD-to-7-seg decoder.

---
 rtl/seg_scan_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for NDIG seven-segment
// digits sharing one BCD decoder. Each digit slot is a dark GAP period
// followed by a SHOW period. Digit values are double-buffered, and the
// active copy only changes at a frame boundary, so a frame is never torn.
module seg_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int DIV   = 1000,
    parameter int DWELL = 4,
    parameter int GAP   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NDIG-1:0]         digits_in,
    input  logic                      lz_blank,
    output logic [3:0]                dec_data,
    output logic [NDIG-1:0]           sel_n,
    output logic [$clog2(NDIG)-1:0]   digit_idx,
    output logic                      upd_pending,
    output logic                      frame_done
);

    localparam int IW   = $clog2(NDIG);
    localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0]   PRE_LAST  = PW'(DIV - 1);
    localparam logic [TW-1:0]   SHOW_LAST = TW'(DWELL - 1);
    localparam logic [TW-1:0]   GAP_LAST  = TW'(GAP - 1);
    localparam logic [IW-1:0]   IDX_LAST  = IW'(NDIG - 1);
    localparam logic [NDIG-1:0] SEL_OFF   = {NDIG{1'b1}};

    typedef enum logic {
        ST_GAP  = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    // Nibble i of a packed digit vector.
    function automatic logic [3:0] nibble_at(input logic [4*NDIG-1:0] v,
                                             input logic [IW-1:0]     i);
        nibble_at = v[4*int'(i) +: 4];
    endfunction

    // True when digit i is a leading zero: it and all higher digits are 0.
    // Digit 0 is never a leading zero so a value of 0 still shows "0".
    function automatic logic lead_zero(input logic [4*NDIG-1:0] v,
                                       input logic [IW-1:0]     i);
        logic nz;
        nz = 1'b0;
        for (int j = 0; j < NDIG; j++) begin
            if ((j >= int'(i)) && (v[4*j +: 4] != 4'h0)) begin
                nz = 1'b1;
            end else begin
                nz = nz;
            end
        end
        lead_zero = (i != {IW{1'b0}}) && !nz;
    endfunction

    // One-hot-low select for digit i.
    function automatic logic [NDIG-1:0] sel_for(input logic [IW-1:0] i);
        logic [NDIG-1:0] s;
        s    = SEL_OFF;
        s[i] = 1'b0;
        sel_for = s;
    endfunction

    state_t             state_r, state_s;
    logic [PW-1:0]      pre_r, pre_s;
    logic [TW-1:0]      tcnt_r, tcnt_s;
    logic [IW-1:0]      idx_r, idx_s;
    logic [4*NDIG-1:0]  active_r, active_s;
    logic [4*NDIG-1:0]  shadow_r, shadow_s;
    logic               pend_r, pend_s;
    logic [NDIG-1:0]    sel_r, sel_s;
    logic [3:0]         dec_r, dec_s;
    logic               fdone_r, fdone_s;
    logic               tick_s;
    logic               boundary_s;
    logic               enter_show_s;

    // Next-state and next-output logic: prescaler, slot FSM, buffering, blanking.
    always_comb begin
        state_s      = state_r;
        pre_s        = pre_r;
        tcnt_s       = tcnt_r;
        idx_s        = idx_r;
        active_s     = active_r;
        shadow_s     = shadow_r;
        pend_s       = pend_r;
        sel_s        = sel_r;
        dec_s        = dec_r;
        fdone_s      = 1'b0;
        tick_s       = (pre_r == PRE_LAST);
        boundary_s   = 1'b0;
        enter_show_s = 1'b0;

        if (!en) begin
            // Disabled: go dark and park at the start of the digit 0 GAP.
            pre_s   = {PW{1'b0}};
            tcnt_s  = {TW{1'b0}};
            state_s = ST_GAP;
            idx_s   = {IW{1'b0}};
            sel_s   = SEL_OFF;
            dec_s   = nibble_at(active_r, {IW{1'b0}});
        end else begin
            pre_s = tick_s ? {PW{1'b0}} : (pre_r + PW'(1));
            if (tick_s) begin
                case (state_r)
                    ST_GAP: begin
                        if (tcnt_r == GAP_LAST) begin
                            state_s      = ST_SHOW;
                            tcnt_s       = {TW{1'b0}};
                            enter_show_s = 1'b1;
                            boundary_s   = (idx_r == {IW{1'b0}});
                        end else begin
                            tcnt_s = tcnt_r + TW'(1);
                        end
                    end
                    ST_SHOW: begin
                        if (tcnt_r == SHOW_LAST) begin
                            state_s = ST_GAP;
                            tcnt_s  = {TW{1'b0}};
                            idx_s   = (idx_r == IDX_LAST) ? {IW{1'b0}} : (idx_r + IW'(1));
                            fdone_s = (idx_r == IDX_LAST);
                            sel_s   = SEL_OFF;
                            // Present the next digit a full GAP ahead of its select.
                            dec_s   = nibble_at(active_r, idx_s);
                        end else begin
                            tcnt_s = tcnt_r + TW'(1);
                        end
                    end
                    default: begin
                        state_s = ST_GAP;
                        tcnt_s  = {TW{1'b0}};
                        sel_s   = SEL_OFF;
                    end
                endcase
            end else begin
                tcnt_s = tcnt_r;
            end
        end

        // Double buffering: a load on the boundary edge bypasses the shadow.
        if (boundary_s) begin
            if (load) begin
                active_s = digits_in;
                shadow_s = digits_in;
                pend_s   = 1'b0;
            end else if (pend_r) begin
                active_s = shadow_r;
                pend_s   = 1'b0;
            end else begin
                active_s = active_r;
            end
            dec_s = nibble_at(active_s, {IW{1'b0}});
        end else if (load) begin
            shadow_s = digits_in;
            pend_s   = 1'b1;
        end else begin
            shadow_s = shadow_r;
        end

        // Select for the new SHOW, judged against the digits it will display.
        if (enter_show_s) begin
            if (lz_blank && lead_zero(active_s, idx_s)) begin
                sel_s = SEL_OFF;
            end else begin
                sel_s = sel_for(idx_s);
            end
        end else begin
            sel_s = sel_s;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_GAP;
            pre_r    <= {PW{1'b0}};
            tcnt_r   <= {TW{1'b0}};
            idx_r    <= {IW{1'b0}};
            active_r <= {(4*NDIG){1'b0}};
            shadow_r <= {(4*NDIG){1'b0}};
            pend_r   <= 1'b0;
            sel_r    <= SEL_OFF;
            dec_r    <= 4'h0;
            fdone_r  <= 1'b0;
        end else begin
            state_r  <= state_s;
            pre_r    <= pre_s;
            tcnt_r   <= tcnt_s;
            idx_r    <= idx_s;
            active_r <= active_s;
            shadow_r <= shadow_s;
            pend_r   <= pend_s;
            sel_r    <= sel_s;
            dec_r    <= dec_s;
            fdone_r  <= fdone_s;
        end
    end

    assign dec_data    = dec_r;
    assign sel_n       = sel_r;
    assign digit_idx   = idx_r;
    assign upd_pending = pend_r;
    assign frame_done  = fdone_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NDIG=4, DIV=4, DWELL=2, GAP=1
// (GAP = 4 clk, SHOW = 8 clk, slot = 12 clk, frame = 48 clk).
// The reference model tracks only the clock position inside the frame
// and the active/shadow digit values.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic        lz_blank;
    logic [3:0]  dec_data;
    logic [3:0]  sel_n;
    logic [1:0]  digit_idx;
    logic        upd_pending;
    logic        frame_done;

    seg_scan_ctrl #(
        .NDIG  (4),
        .DIV   (4),
        .DWELL (2),
        .GAP   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .load        (load),
        .digits_in   (digits_in),
        .lz_blank    (lz_blank),
        .dec_data    (dec_data),
        .sel_n       (sel_n),
        .digit_idx   (digit_idx),
        .upd_pending (upd_pending),
        .frame_done  (frame_done)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    int          k = 0;          // enabled clocks since the scan (re)started
    logic [15:0] act_m = 16'h0;
    logic [15:0] shd_m = 16'h0;
    logic        pend_m = 1'b0;
    logic        fd_m = 1'b0;
    logic        lz_l = 1'b0;    // lz_blank seen when the current SHOW began

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs being driven.
    task automatic model_edge();
        int pos;
        fd_m = 1'b0;
        if (!rst_n) begin
            k = 0; act_m = 16'h0; shd_m = 16'h0; pend_m = 1'b0; lz_l = 1'b0;
        end else if (!en) begin
            k = 0;
            if (load) begin shd_m = digits_in; pend_m = 1'b1; end
        end else begin
            k++;
            pos = k % 48;
            if (pos == 4) begin
                if (load) begin act_m = digits_in; pend_m = 1'b0; end
                else if (pend_m) begin act_m = shd_m; pend_m = 1'b0; end
            end else if (load) begin
                shd_m = digits_in; pend_m = 1'b1;
            end
            if (pos % 12 == 4) lz_l = lz_blank;
            if (pos == 0) fd_m = 1'b1;
        end
    endtask

    // One clock: update the model, then compare every output after the edge.
    task automatic step();
        int pos, slot;
        bit show, blank;
        logic [3:0] e_sel, e_dec;
        @(posedge clk);
        model_edge();
        #1;
        pos   = k % 48;
        slot  = pos / 12;
        show  = (pos % 12) >= 4;
        blank = lz_l && (slot != 0) && ((act_m >> (4 * slot)) == 16'h0);
        e_sel = (show && !blank) ? ~(4'b0001 << slot) : 4'b1111;
        e_dec = 4'((act_m >> (4 * slot)) & 16'h000F);
        check("m.sel_n", sel_n, e_sel);
        check("m.dec_data", dec_data, e_dec);
        check("m.digit_idx", digit_idx, slot[1:0]);
        check("m.upd_pending", upd_pending, pend_m);
        check("m.frame_done", frame_done, fd_m);
    endtask

    // Step until the frame position reaches pos, with a cycle budget.
    task automatic run_to(input int pos);
        bit hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (k % 48 == pos) begin hit = 1'b1; break; end
        end
        tests++;
        if (!hit) begin
            fails++;
            $display("FAIL run_to: position %0d not reached, k=%0d", pos, k);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic        en;
        logic        load;
        logic [15:0] din;
        logic        lz;
        int          cycles;
        logic [3:0]  e_sel;
        logic [3:0]  e_dec;
        logic [1:0]  e_idx;
        logic        e_pend;
        logic        e_fd;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    initial begin
        // rst, en, load, din, lz, cycles | sel, dec, idx, pend, fd
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0,  3, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,  3, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0,  1, 4'hE, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b0,  1, 4'hE, 4'h0, 2'd0, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0,  7, 4'hF, 4'h0, 2'd1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 36, 4'hF, 4'h0, 2'd0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0,  4, 4'hE, 4'h4, 2'd0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 12, 4'hD, 4'h3, 2'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 12, 4'hB, 4'h2, 2'd2, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 12, 4'h7, 4'h1, 2'd3, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0,  8, 4'hF, 4'h4, 2'd0, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0050, 1'b1,  1, 4'hF, 4'h4, 2'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h0050, 1'b1,  3, 4'hE, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0050, 1'b1, 12, 4'hD, 4'h5, 2'd1, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 16'h0050, 1'b1, 12, 4'hF, 4'h0, 2'd2, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0050, 1'b1, 12, 4'hF, 4'h0, 2'd3, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16'h0050, 1'b0, 38, 4'hB, 4'h0, 2'd2, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 16'h0050, 1'b0,  1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 16'h1234, 1'b0,  2, 4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0,  3, 4'hF, 4'h0, 2'd0, 1'b1, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0,  1, 4'hE, 4'h4, 2'd0, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 26, 4'hB, 4'h2, 2'd2, 1'b0, 1'b0};
        vecs[22] = '{1'b1, 1'b1, 1'b1, 16'h5678, 1'b0,  1, 4'hB, 4'h2, 2'd2, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b1, 1'b0, 16'h5678, 1'b0,  1, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[24] = '{1'b1, 1'b1, 1'b0, 16'h5678, 1'b0,  4, 4'hE, 4'h0, 2'd0, 1'b0, 1'b0};
        vecs[25] = '{1'b1, 1'b1, 1'b0, 16'h5678, 1'b0, 12, 4'hD, 4'h0, 2'd1, 1'b0, 1'b0};

        rst_n = 1'b0; en = 1'b1; load = 1'b0; digits_in = 16'h0; lz_blank = 1'b0;

        // Directed table: reset, normal scan, blanking, enable and reset mid-frame.
        for (int r = 0; r < NV; r++) begin
            rst_n     = vecs[r].rst_n;
            en        = vecs[r].en;
            digits_in = vecs[r].din;
            lz_blank  = vecs[r].lz;
            load      = vecs[r].load;
            for (int c = 0; c < vecs[r].cycles; c++) begin
                step();
                load = 1'b0;
            end
            check($sformatf("v%0d.sel_n", r), sel_n, vecs[r].e_sel);
            check($sformatf("v%0d.dec_data", r), dec_data, vecs[r].e_dec);
            check($sformatf("v%0d.digit_idx", r), digit_idx, vecs[r].e_idx);
            check($sformatf("v%0d.upd_pending", r), upd_pending, vecs[r].e_pend);
            check($sformatf("v%0d.frame_done", r), frame_done, vecs[r].e_fd);
        end

        // Two loads during digit1 SHOW: last wins, applied at the next boundary.
        load = 1'b1; digits_in = 16'h9999; step();
        load = 1'b0; step();
        load = 1'b1; digits_in = 16'h8888; step();
        load = 1'b0;
        run_to(3);
        check("dbl.pend_before", upd_pending, 1'b1);
        check("dbl.dec_before", dec_data, 4'h0);
        step();
        check("dbl.dec_after", dec_data, 4'h8);
        check("dbl.pend_after", upd_pending, 1'b0);
        check("dbl.sel_after", sel_n, 4'hE);

        // Load on the boundary edge goes straight to the active digits.
        run_to(3);
        load = 1'b1; digits_in = 16'h00A0; step();
        load = 1'b0;
        check("bnd.pend", upd_pending, 1'b0);
        check("bnd.dec0", dec_data, 4'h0);
        check("bnd.sel0", sel_n, 4'hE);
        run_to(16);
        check("bnd.dec1", dec_data, 4'hA);
        check("bnd.sel1", sel_n, 4'hD);

        // All-zero value with blanking: only digit 0 is ever selected.
        lz_blank = 1'b1;
        load = 1'b1; digits_in = 16'h0000; step();
        load = 1'b0;
        run_to(4);
        for (int i = 0; i < 48; i++) begin
            step();
            check("zero.only_d0", ((sel_n == 4'hF || sel_n == 4'hE) && dec_data == 4'h0), 1'b1);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            rst_n     = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 199) != 0);
            load      = ($urandom_range(0, 9) == 0);
            digits_in = 16'($urandom);
            if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
